addr_latch_decoder: RTL and testbench



---
 rtl/addr_latch_decoder.sv | 141 ++++++++++++++
 tb/tb_addr_latch_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/addr_latch_decoder.sv
// addr_latch_decoder
//   Multi-channel clocked address decoder. Every channel has 2**ADDR_W
//   registered output lines selected by one shared address. Per-channel
//   active-low strobes qualify a write. A global mode selects one of:
//   addressable latch, demultiplexer, timed one-shot pulse, or clear.
//
// Parameters
//   ADDR_W    : address width, N = 2**ADDR_W lines per channel (1..5)
//   CHANNELS  : number of independent channels (1..8)
//   PULSE_LEN : one-shot high time in clock cycles (1..255)
//
// Ports
//   _CLK   in  1            clock, rising edge
//   _RESET in  1            synchronous active-high reset
//   _A     in  ADDR_W       shared line address
//   _D     in  CHANNELS     data bit per channel
//   _G     in  CHANNELS     active-low strobe per channel
//   _MODE  in  2            00 latch, 01 demux, 10 pulse, 11 clear
//   _Q     out CHANNELS*N   registered lines, channel c line a at c*N+a
//   _BUSY  out CHANNELS     one-shot running per channel
module addr_latch_decoder #(
  parameter int ADDR_W    = 2,
  parameter int CHANNELS  = 2,
  parameter int PULSE_LEN = 4
) (
  input  logic                             _CLK,
  input  logic                             _RESET,
  input  logic [ADDR_W-1:0]                _A,
  input  logic [CHANNELS-1:0]              _D,
  input  logic [CHANNELS-1:0]              _G,
  input  logic [1:0]                       _MODE,
  output logic [CHANNELS*(2**ADDR_W)-1:0]  _Q,
  output logic [CHANNELS-1:0]              _BUSY
);

  localparam int N     = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_LATCH = 2'b00,
    MODE_DEMUX = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  logic [CHANNELS*N-1:0]            q_r;
  logic [CHANNELS*N-1:0]            q_nxt_s;
  logic [CHANNELS-1:0]              busy_r;
  logic [CHANNELS-1:0]              busy_nxt_s;
  logic [CHANNELS-1:0][CNT_W-1:0]   cnt_r;
  logic [CHANNELS-1:0][CNT_W-1:0]   cnt_nxt_s;
  // Previous strobe level; 0 after reset so a strobe held low through
  // reset release is not mistaken for a fresh edge.
  logic [CHANNELS-1:0]              hist_r;
  logic [N-1:0]                     sel_s;
  mode_e                            mode_s;

  assign _Q    = q_r;
  assign _BUSY = busy_r;

  // Next-state computation for all channels' lines, counters and busy flags.
  always_comb begin
    q_nxt_s    = q_r;
    busy_nxt_s = busy_r;
    cnt_nxt_s  = cnt_r;
    sel_s      = {{(N-1){1'b0}}, 1'b1} << _A;
    mode_s     = mode_e'(_MODE);
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_s)
        MODE_LATCH: begin
          // Leaving pulse mode aborts the timer but keeps the line level.
          cnt_nxt_s[c]  = '0;
          busy_nxt_s[c] = 1'b0;
          if (!_G[c]) begin
            q_nxt_s[c*N + int'(_A)] = _D[c];
          end else begin
            q_nxt_s[c*N +: N] = q_r[c*N +: N];
          end
        end
        MODE_DEMUX: begin
          cnt_nxt_s[c]  = '0;
          busy_nxt_s[c] = 1'b0;
          if (!_G[c]) begin
            q_nxt_s[c*N +: N] = sel_s & {N{_D[c]}};
          end else begin
            q_nxt_s[c*N +: N] = q_r[c*N +: N];
          end
        end
        MODE_PULSE: begin
          if (!_G[c] && hist_r[c]) begin
            // Fresh edge (also a retrigger): move the pulse to the new
            // line in one step so there is neither gap nor overlap.
            q_nxt_s[c*N +: N] = sel_s;
            cnt_nxt_s[c]      = CNT_LOAD;
            busy_nxt_s[c]     = 1'b1;
          end else if (cnt_r[c] != '0) begin
            cnt_nxt_s[c] = cnt_r[c] - CNT_ONE;
            if (cnt_r[c] == CNT_ONE) begin
              // Only the pulsed line can be high here: the edge cleared
              // the rest and nothing else writes in pulse mode.
              q_nxt_s[c*N +: N] = '0;
              busy_nxt_s[c]     = 1'b0;
            end else begin
              busy_nxt_s[c] = 1'b1;
            end
          end else begin
            cnt_nxt_s[c] = '0;
          end
        end
        MODE_CLEAR: begin
          q_nxt_s[c*N +: N] = '0;
          cnt_nxt_s[c]      = '0;
          busy_nxt_s[c]     = 1'b0;
        end
        default: begin
          q_nxt_s[c*N +: N] = '0;
          cnt_nxt_s[c]      = '0;
          busy_nxt_s[c]     = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; history always tracks the strobe.
  always_ff @(posedge _CLK) begin
    if (_RESET) begin
      q_r    <= '0;
      busy_r <= '0;
      cnt_r  <= '0;
      hist_r <= '0;
    end else begin
      q_r    <= q_nxt_s;
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
      hist_r <= _G;
    end
  end

endmodule

// File: tb/tb_addr_latch_decoder.sv
module tb_addr_latch_decoder;

  logic       clk;
  logic       rst;
  // Instance 0: defaults (ADDR_W=2, CHANNELS=2, PULSE_LEN=4)
  logic [1:0] a0;
  logic [1:0] d0;
  logic [1:0] g0;
  logic [1:0] mode0;
  logic [7:0] q0;
  logic [1:0] busy0;
  // Instance 1: ADDR_W=3, CHANNELS=1, PULSE_LEN=1
  logic [2:0] a1;
  logic [0:0] d1;
  logic [0:0] g1;
  logic [1:0] mode1;
  logic [7:0] q1;
  logic [0:0] busy1;

  int checks = 0;
  int errors = 0;
  int high_cnt;

  addr_latch_decoder u_dut0 (
    ._CLK(clk), ._RESET(rst), ._A(a0), ._D(d0), ._G(g0), ._MODE(mode0),
    ._Q(q0), ._BUSY(busy0)
  );

  addr_latch_decoder #(.ADDR_W(3), .CHANNELS(1), .PULSE_LEN(1)) u_dut1 (
    ._CLK(clk), ._RESET(rst), ._A(a1), ._D(d1), ._G(g1), ._MODE(mode1),
    ._Q(q1), ._BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a0 = '0; d0 = '0; g0 = 2'b11; mode0 = 2'b00;
    a1 = '0; d1 = '0; g1 = 1'b1; mode1 = 2'b00;
    step(); step();
    check_eq("reset_q0", 32'(q0), 32'h00);
    check_eq("reset_busy0", 32'(busy0), 32'h0);
    check_eq("reset_q1", 32'(q1), 32'h00);
    rst = 1'b0;
    step();

    // LATCH
    a0 = 2'd2; d0 = 2'b01; g0 = 2'b10; step();
    check_eq("latch_ch0_a2", 32'(q0), 32'h04);
    a0 = 2'd3; d0 = 2'b10; g0 = 2'b01; step();
    check_eq("latch_ch1_a3", 32'(q0), 32'h84);
    a0 = 2'd2; d0 = 2'b00; g0 = 2'b10; step();
    check_eq("latch_ch0_clr", 32'(q0), 32'h80);
    for (int a = 0; a < 4; a++) begin
      a0 = 2'(a); d0 = 2'b01; g0 = 2'b10; step();
    end
    a0 = 2'd3; d0 = 2'b00; g0 = 2'b01; step();
    check_eq("latch_0f", 32'(q0), 32'h0F);

    // DEMUX
    mode0 = 2'b01; a0 = 2'd1; d0 = 2'b01; g0 = 2'b10; step();
    check_eq("demux_a1", 32'(q0), 32'h02);
    g0 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("demux_hold", 32'(q0), 32'h02);
    end

    // PULSE single one-cycle strobe on ch1 line 0
    mode0 = 2'b10; step();
    a0 = 2'd0; g0 = 2'b01; step();
    g0 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      check_eq("pulse_q_high", 32'(q0), 32'h12);
      check_eq("pulse_busy_high", 32'(busy0), 32'h2);
      step();
    end
    check_eq("pulse_q_end", 32'(q0), 32'h02);
    check_eq("pulse_busy_end", 32'(busy0), 32'h0);

    // Strobe held low for 10 cycles: one pulse only
    high_cnt = 0;
    g0 = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      if (q0[4]) high_cnt++;
    end
    g0 = 2'b11;
    check_eq("held_low_len", 32'(high_cnt), 32'd4);
    check_eq("held_low_end", 32'(q0), 32'h02);
    step();

    // Retrigger: a=1 at t=0, a=3 at t=2
    for (int t = 0; t < 8; t++) begin
      g0 = (t == 0 || t == 2) ? 2'b01 : 2'b11;
      a0 = (t == 2) ? 2'd3 : 2'd1;
      step();
      check_eq("retrig_q", 32'(q0), 32'({(t < 2) ? 4'b0010 : (t < 6) ? 4'b1000 : 4'b0000, 4'h2}));
      check_eq("retrig_busy", 32'(busy0), 32'({(t < 6) ? 1'b1 : 1'b0, 1'b0}));
    end
    g0 = 2'b11;

    // Mode switch mid-pulse, then CLEAR
    a0 = 2'd2; g0 = 2'b01; step();
    g0 = 2'b11; step();
    mode0 = 2'b00; step();
    check_eq("modesw_q", 32'(q0), 32'h42);
    check_eq("modesw_busy", 32'(busy0), 32'h0);
    mode0 = 2'b11; step();
    check_eq("clear_q", 32'(q0), 32'h00);
    check_eq("clear_busy", 32'(busy0), 32'h0);

    // Retrigger on the would-expire cycle, ch0
    mode0 = 2'b10; step();
    for (int t = 0; t < 9; t++) begin
      g0 = (t == 0 || t == 4) ? 2'b10 : 2'b11;
      a0 = (t == 4) ? 2'd1 : 2'd0;
      step();
      check_eq("expire_retrig_q", 32'(q0), 32'({4'h0, (t < 4) ? 4'b0001 : (t < 8) ? 4'b0010 : 4'b0000}));
      check_eq("expire_retrig_busy", 32'(busy0), 32'({1'b0, (t < 8) ? 1'b1 : 1'b0}));
    end

    // Reset mid-pulse with strobe held low across release
    a0 = 2'd0; g0 = 2'b01; step();
    check_eq("pre_reset_pulse", 32'(q0), 32'h10);
    rst = 1'b1; step();
    check_eq("reset_mid_q", 32'(q0), 32'h00);
    check_eq("reset_mid_busy", 32'(busy0), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("post_reset_q", 32'(q0), 32'h00);
      check_eq("post_reset_busy", 32'(busy0), 32'h0);
    end
    g0 = 2'b11;

    // Instance 1: all 8 lines latched
    for (int a = 0; a < 8; a++) begin
      a1 = 3'(a); d1 = 1'b1; g1 = 1'b0; step();
      check_eq("w8_latch", 32'(q1), (32'd1 << (a + 1)) - 32'd1);
    end
    mode1 = 2'b01; a1 = 3'd5; step();
    check_eq("w8_demux", 32'(q1), 32'h20);
    g1 = 1'b1; mode1 = 2'b10; step();
    check_eq("w8_pulse_idle", 32'(q1), 32'h20);
    for (int t = 0; t < 8; t++) begin
      g1 = (t % 2 == 0) ? 1'b0 : 1'b1;
      a1 = 3'(t / 2);
      step();
      check_eq("w8_pulse_q", 32'(q1), (t % 2 == 0) ? (32'd1 << (t / 2)) : 32'd0);
      check_eq("w8_pulse_busy", 32'(busy1), (t % 2 == 0) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
